// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
//   Shared declarations for the sequential restoring divider.
//   - div_state_e : controller state encoding (IDLE, RUN, DONE)
//   - DIV_CNT_W   : step-counter width for the default 4-bit divider
//   - div_cnt_width() : step-counter width for any operand width
// ----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;
  localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT);

  // The counter walks 0 .. width-1, so $clog2(width) bits suffice.
  // Clamp to one bit so a degenerate width never yields a zero-width vector.
  function automatic int div_cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/fulladder.sv
// ----------------------------------------------------------------------------
// fulladder
//   Parameterised ripple-carry adder: {c_o, sum_o} = a_i + b_i + y_i.
//   Used by the divider as the trial subtractor (b_i = ~divisor, y_i = 1).
//
//   Ports
//     a_i   in  WIDTH  first operand
//     b_i   in  WIDTH  second operand
//     y_i   in  1      carry-in
//     sum_o out WIDTH  sum
//     c_o   out 1      carry-out
// ----------------------------------------------------------------------------
module fulladder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             y_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  // The carry ripples through a block-local variable so the whole chain is
  // evaluated in one process rather than as a self-referencing vector.
  always_comb begin
    logic carry;
    carry = y_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider. One quotient bit is resolved per
//   clock over WIDTH cycles; each trial subtraction is done by a single
//   fulladder instance of WIDTH+1 bits.
//
//   Handshake: start is sampled only while the controller is IDLE; the edge
//   that sees start=1 in IDLE captures dividend/divisor and begins a
//   division. start in RUN or DONE is dropped, never queued. done is a
//   one-cycle pulse in the DONE state; quotient/remainder are valid from that
//   cycle and hold until the next division completes. div_by_zero is updated
//   at the accepting edge and is meaningful only when qualified with done.
//
//   Ports
//     clk          in  1      rising-edge clock
//     rst_n        in  1      asynchronous active-low reset
//     start        in  1      division request
//     dividend     in  WIDTH  numerator (sampled with start)
//     divisor      in  WIDTH  denominator (sampled with start)
//     busy         out 1      high while in RUN
//     done         out 1      one-cycle result-valid pulse
//     quotient     out WIDTH  registered quotient
//     remainder    out WIDTH  registered remainder
//     div_by_zero  out 1      registered; divisor of the latest accept was 0
//     dbg_state    out 2      current controller state (div_state_e)
// ----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;     // captured divisor D
  logic [WIDTH-1:0] q_q, q_d;         // dividend shifting out / quotient in
  // Partial remainder. The algorithm keeps R at WIDTH+1 bits, but after every
  // step R < D <= 2^WIDTH-1, so its top bit is always 0; only the low WIDTH
  // bits are stored and the shifted value is rebuilt at WIDTH+1 bits below.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // --------------------------------------------------------------------------
  // Datapath: one restoring step
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   r_shift;          // R' = {R[WIDTH-1:0], Q[WIDTH-1]}
  logic [WIDTH:0]   diff;             // R' - D
  logic             no_borrow;        // carry-out of R' + ~D + 1
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic             last_step;
  logic             accept;
  logic             unused_diff_msb;

  assign r_shift = {r_q, q_q[WIDTH-1]};

  fulladder #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a_i   (r_shift),
    .b_i   (~{1'b0, dvs_q}),
    .y_i   (1'b1),
    .sum_o (diff),
    .c_o   (no_borrow)
  );

  // When there is no borrow, diff < D, so diff[WIDTH] is always 0 and the
  // low WIDTH bits carry the full new remainder.
  assign unused_diff_msb = diff[WIDTH];

  assign q_step    = {q_q[WIDTH-2:0], no_borrow};
  assign r_step    = no_borrow ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign last_step = (cnt_q == LAST_STEP);
  assign accept    = (state_q == IDLE) && start;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    dvs_d  = dvs_q;
    q_d    = q_q;
    r_d    = r_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;

    if (accept) begin
      // Result registers are deliberately left alone here: the previous
      // result stays visible until this division completes.
      dvs_d = divisor;
      q_d   = dividend;
      r_d   = '0;
      cnt_d = '0;
      dbz_d = (divisor == '0);
    end else if (state_q == RUN) begin
      q_d   = q_step;
      r_d   = r_step;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        quot_d = q_step;
        rem_d  = r_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvs_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvs_q  <= dvs_d;
      q_q    <= q_d;
      r_q    <= r_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 4;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dbg_state == IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: state=%0d after 30 cycles, required IDLE", dbg_state);
    end
  endtask

  // Issue one division and observe it to completion. lat is the number of
  // edges from the accepting edge to the edge that raised done (-1 on timeout).
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output logic dbz_early,
                        output int lat, output int busy_cyc,
                        output logic done_after);
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;   // must be ignored after the accepting edge
    divisor  = ~b;
    lat       = -1;
    busy_cyc  = 0;
    q         = '0;
    r         = '0;
    dbz       = 1'b0;
    dbz_early = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) dbz_early = div_by_zero;
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r;
    logic dbz, dbz_e, dn_after;
    int lat, bc;
    do_div(4'd13, 4'd4, q, r, dbz, dbz_e, lat, bc, dn_after);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL basic_quotient: got %0d want 3", q); end
    checks++; if (r !== 4'd1) begin errors++; $display("FAIL basic_remainder: got %0d want 1", r); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", dbz); end
    checks++; if (dn_after !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done after pulse %b want 0", dn_after); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] q, r;
    logic dbz, dbz_e, dn_after;
    int lat, bc;
    do_div(4'd15, 4'd1, q, r, dbz, dbz_e, lat, bc, dn_after);
    checks++; if (q !== 4'd15) begin errors++; $display("FAIL vec_15_1_quotient: got %0d want 15", q); end
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL vec_15_1_remainder: got %0d want 0", r); end
    do_div(4'd7, 4'd9, q, r, dbz, dbz_e, lat, bc, dn_after);
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL vec_7_9_quotient: got %0d want 0", q); end
    checks++; if (r !== 4'd7) begin errors++; $display("FAIL vec_7_9_remainder: got %0d want 7", r); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic dbz, dbz_e, dn_after;
    int lat, bc;
    do_div(4'd9, 4'd0, q, r, dbz, dbz_e, lat, bc, dn_after);
    checks++; if (dbz_e !== 1'b1) begin errors++; $display("FAIL dz_early_flag: got %b want 1 right after accept", dbz_e); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL dz_latency: got %0d want 4", lat); end
    checks++; if (q !== 4'd15) begin errors++; $display("FAIL dz_quotient: got %0d want 15", q); end
    checks++; if (r !== 4'd9) begin errors++; $display("FAIL dz_remainder: got %0d want 9", r); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dbz); end
  endtask

  task automatic test_ignore_start();
    int n_done;
    logic [W-1:0] q, r;
    wait_idle();
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    @(posedge clk);              // E0 accepts
    #1;
    start = 1'b0;
    @(posedge clk);              // E1
    #1;
    start    = 1'b1;             // seen at E2 while in RUN
    dividend = 4'd2;
    divisor  = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    q = '0;
    r = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        q = quotient;
        r = remainder;
      end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL ignore_quotient: got %0d want 3", q); end
    checks++; if (r !== 4'd1) begin errors++; $display("FAIL ignore_remainder: got %0d want 1", r); end
    checks++; if (quotient !== 4'd3 || remainder !== 4'd1) begin
      errors++; $display("FAIL ignore_hold: got %0d r%0d want 3 r1", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    logic [W-1:0] q, r;
    logic dbz, dbz_e, dn_after;
    int lat, bc;
    wait_idle();
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd0;             // sets div_by_zero so its clear is visible
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;                // mid-RUN, between edges
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL midrst_quotient: got %0d want 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL midrst_remainder: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dbz: got %b want 0", div_by_zero); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    n_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_done); end
    do_div(4'd6, 4'd4, q, r, dbz, dbz_e, lat, bc, dn_after);
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL midrst_after_quotient: got %0d want 1", q); end
    checks++; if (r !== 4'd2) begin errors++; $display("FAIL midrst_after_remainder: got %0d want 2", r); end
  endtask

  task automatic test_back_to_back();
    int n_done, last, n_unstable;
    wait_idle();
    start    = 1'b1;
    dividend = 4'd10;
    divisor  = 4'd3;
    n_done     = 0;
    last       = -1;
    n_unstable = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (quotient !== 4'd3 || remainder !== 4'd1) begin
          errors++; $display("FAIL b2b_result: got %0d r%0d want 3 r1", quotient, remainder);
        end
        if (last >= 0) begin
          checks++;
          if (c - last !== 6) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles want 6", c - last);
          end
        end
        last = c;
        n_done++;
      end else if (n_done > 0 && (quotient !== 4'd3 || remainder !== 4'd1)) begin
        n_unstable++;
      end
    end
    start = 1'b0;
    checks++; if (n_done !== 6) begin errors++; $display("FAIL b2b_done_count: got %0d want 6", n_done); end
    checks++; if (n_unstable !== 0) begin errors++; $display("FAIL b2b_stable: %0d unstable cycles want 0", n_unstable); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] q, r, exp_q, exp_r;
    logic dbz, dbz_e, dn_after, exp_dbz;
    int lat, bc;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(W'(a), W'(b), q, r, dbz, dbz_e, lat, bc, dn_after);
        if (b == 0) begin
          exp_q   = 4'd15;
          exp_r   = W'(a);
          exp_dbz = 1'b1;
        end else begin
          exp_q   = W'(a / b);
          exp_r   = W'(a % b);
          exp_dbz = 1'b0;
        end
        checks++;
        if (lat !== 4 || q !== exp_q || r !== exp_r || dbz !== exp_dbz) begin
          errors++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=4",
                   a, b, q, r, dbz, lat, exp_q, exp_r, exp_dbz);
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
